// File: rtl/store_buffer.sv
// Posted-write store buffer: formats stores into word-aligned bus writes and
// queues them in a circular FIFO, reporting load address hits on pending entries.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stValid,
    output logic        stReady,
    input  logic [31:0] stAddr,
    input  logic [2:0]  stFunt3,
    input  logic [31:0] stData,
    output logic        memValid,
    input  logic        memReady,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memWstrb,
    input  logic [31:0] ldAddr,
    output logic        ldHit,
    output logic        misalignErr,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       strb_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic [1:0]  off;
    logic        fmt_ok;
    logic [3:0]  fmt_strb;
    logic [31:0] fmt_data;
    logic        accept, enq, pop;
    logic        unused_ld;

    assign unused_ld = ^ldAddr[1:0];

    always_comb begin
        off      = stAddr[1:0];
        fmt_ok   = 1'b0;
        fmt_strb = 4'b0000;
        fmt_data = 32'h0;
        case (stFunt3)
            3'b000: begin
                fmt_ok   = 1'b1;
                fmt_strb = 4'b0001 << off;
                fmt_data = {24'h0, stData[7:0]} << {off, 3'b000};
            end
            3'b001: begin
                fmt_ok   = ~stAddr[0];
                fmt_strb = 4'b0011 << off;
                fmt_data = {16'h0, stData[15:0]} << {off, 3'b000};
            end
            3'b010: begin
                fmt_ok   = (off == 2'b00);
                fmt_strb = 4'b1111;
                fmt_data = stData;
            end
            default: begin
                fmt_ok = 1'b0;
            end
        endcase
    end

    assign stReady  = (count_q != FULL);
    assign memValid = (count_q != '0);
    assign empty    = (count_q == '0);
    assign accept   = stValid && stReady;
    assign enq      = accept && fmt_ok;
    assign pop      = memValid && memReady;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        vld_d   = vld_q;
        err_d   = accept && !fmt_ok;
        if (pop) begin
            rd_d        = rd_q + 1'b1;
            vld_d[rd_q] = 1'b0;
        end
        if (enq) begin
            wr_d        = wr_q + 1'b1;
            vld_d[wr_q] = 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            vld_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q/count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_q] <= stAddr[31:2];
            data_q[wr_q] <= fmt_data;
            strb_q[wr_q] <= fmt_strb;
        end
    end

    assign misalignErr = err_q;
    assign memAddr     = memValid ? {addr_q[rd_q], 2'b00} : 32'h0;
    assign memWdata    = memValid ? data_q[rd_q] : 32'h0;
    assign memWstrb    = memValid ? strb_q[rd_q] : 4'h0;

    always_comb begin
        ldHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == ldAddr[31:2])) begin
                ldHit = 1'b1;
            end
        end
    end

endmodule
